// File: rtl/dma_voice_arb_pkg.sv
// Shared types and helpers for the DMA voice arbiter.
//   arb_state_t : arbiter FSM state encoding
//   DMA_LEN_W   : width of a burst-length field
//   clogb2      : ceil(log2(value)), never less than 1
package dma_voice_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

  localparam int DMA_LEN_W = 8;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin select.
//   pending    in  : one request bit per voice
//   last_grant in  : most recently accepted voice
//   found      out : at least one voice is pending
//   sel        out : first pending voice at or after last_grant+1 (wrapping)
module dma_rr_picker #(
  parameter int NUM_VOICES = 4,
  parameter int GRANT_W    = 2
) (
  input  logic [NUM_VOICES-1:0] pending,
  input  logic [GRANT_W-1:0]    last_grant,
  output logic                  found,
  output logic [GRANT_W-1:0]    sel
);

  logic [GRANT_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_VOICES; k++) begin
      idx = GRANT_W'((int'(last_grant) + k) % NUM_VOICES);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/dma_voice_arbiter.sv
// Shares one AXI read-master DMA engine among NUM_VOICES voices.
// Each voice's request pulse is latched into a slot; slots are issued one at
// a time in round-robin order and returned beats are routed to the grantee.
//
// Optional macro DMA_VOICE_ARB_TIMEOUT_EN adds a WAIT_DATA watchdog that
// aborts a burst after TIMEOUT_CYCLES beat-less cycles.
//
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   voice_address/_len    : per-voice request slot contents
//   voice_dma_req         : per-voice one-cycle request pulse
//   voice_data            : m_data broadcast to every voice
//   voice_data_valid/last : beat strobes, granted voice only
//   m_dma_req/addr/len    : request to the master engine
//   m_dma_busy            : master cannot accept a request
//   m_data/_valid/_last   : read beats from the master
//   grant_id              : current or last granted voice
//   arb_busy              : FSM not in IDLE
//   timeout_err           : one-cycle watchdog pulse
//
// state     | meaning
// IDLE      | choose next pending voice, register grant
// ISSUE     | present granted slot to master until accepted
// WAIT_DATA | forward beats to grantee until last beat (or watchdog)
module dma_voice_arbiter
  import dma_voice_arb_pkg::*;
#(
  parameter int NUM_VOICES         = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_VOICES-1:0][C_M_AXI_ADDR_WIDTH-1:0] voice_address,
  input  logic [NUM_VOICES-1:0]                        voice_dma_req,
  input  logic [NUM_VOICES-1:0][DMA_LEN_W-1:0]         voice_dma_req_len,
  output logic [C_M_AXI_DATA_WIDTH-1:0]                voice_data,
  output logic [NUM_VOICES-1:0]                        voice_data_valid,
  output logic [NUM_VOICES-1:0]                        voice_data_last,
  output logic                                         m_dma_req,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                m_dma_addr,
  output logic [DMA_LEN_W-1:0]                         m_dma_len,
  input  logic                                         m_dma_busy,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]                m_data,
  input  logic                                         m_data_valid,
  input  logic                                         m_data_last,
  output logic [$clog2(NUM_VOICES)-1:0]                grant_id,
  output logic                                         arb_busy,
  output logic                                         timeout_err
);

  localparam int GRANT_W = clogb2(NUM_VOICES);

  arb_state_t state_q, state_d;

  logic [NUM_VOICES-1:0]                         pending_q, pending_d, pending_clr;
  logic [NUM_VOICES-1:0][C_M_AXI_ADDR_WIDTH-1:0] slot_addr_q;
  logic [NUM_VOICES-1:0][DMA_LEN_W-1:0]          slot_len_q;
  logic [GRANT_W-1:0]                            grant_q, last_grant_q;
  logic [GRANT_W-1:0]                            pick_sel;
  logic                                          pick_found;
  logic                                          accept;
  logic                                          timeout_fire;

  dma_rr_picker #(
    .NUM_VOICES (NUM_VOICES),
    .GRANT_W    (GRANT_W)
  ) u_picker (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .sel        (pick_sel)
  );

  assign accept     = (state_q == ISSUE) && !m_dma_busy;
  assign voice_data = m_data;
  assign grant_id   = grant_q;
  assign arb_busy   = (state_q != IDLE);

  // A new request on the same edge as the accept clear stays pending.
  always_comb begin
    pending_clr = '0;
    if (accept) pending_clr[grant_q] = 1'b1;
    pending_d = (pending_q & ~pending_clr) | voice_dma_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    m_dma_req        = 1'b0;
    m_dma_addr       = '0;
    m_dma_len        = '0;
    voice_data_valid = '0;
    voice_data_last  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) state_d = ISSUE;
      end
      ISSUE: begin
        m_dma_req  = !m_dma_busy;
        m_dma_addr = slot_addr_q[grant_q];
        m_dma_len  = slot_len_q[grant_q];
        if (!m_dma_busy) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        voice_data_valid[grant_q] = m_data_valid;
        // watchdog abort signals end-of-burst with last but no valid
        voice_data_last[grant_q]  = (m_data_valid & m_data_last) | timeout_fire;
        if ((m_data_valid && m_data_last) || timeout_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      slot_addr_q  <= '0;
      slot_len_q   <= '0;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_VOICES - 1);
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (voice_dma_req[i]) begin
          slot_addr_q[i] <= voice_address[i];
          slot_len_q[i]  <= voice_dma_req_len[i];
        end
      end
      if (state_q == IDLE && pick_found) grant_q <= pick_sel;
      if (accept) last_grant_q <= grant_q;
    end
  end

`ifdef DMA_VOICE_ARB_TIMEOUT_EN
  localparam int TO_W = clogb2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;

  // Down-counter reloaded on accept and on every beat; fires on the
  // TIMEOUT_CYCLES-th consecutive beat-less WAIT_DATA cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (accept || (state_q == WAIT_DATA && m_data_valid)) begin
      to_cnt_q <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == WAIT_DATA && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - TO_W'(1);
    end
  end

  assign timeout_fire = (state_q == WAIT_DATA) && !m_data_valid && (to_cnt_q == '0);
  assign timeout_err  = timeout_fire;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_fire   = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
